fp_mul_pipe: RTL and testbench

//  Parametrised, 3-stage pipelined IEEE-754-style floating-point multiplier with

---
 rtl/fp_pkg.sv | 30 +++
 rtl/fp_round_rne.sv | 43 ++++
 rtl/fp_mul_pipe.sv | 160 ++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the parametrised floating-point datapath:
// operand classes, exception flag bit positions and format helpers.
package fp_pkg;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

    // Bit positions inside the 4-bit flag word {invalid, overflow, underflow, inexact}
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN: positive sign, all-ones exponent, top fraction bit set
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] r;
        r = ((64'd1 << exp_w) - 64'd1) << man_w;
        r = r | (64'd1 << (man_w - 1));
        return r;
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Combinational normalise + round-to-nearest-even of a raw significand product.
// The product of two (MAN_W+1)-bit significands lies in [1,4); a leading one in
// the top bit means the value is >= 2 and the exponent moves up by one.
module fp_round_rne #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic        [2*MAN_W+1:0] prod,
    input  logic signed [EXP_W+1:0]   exp_in,
    output logic        [MAN_W-1:0]   frac,
    output logic signed [EXP_W+1:0]   exp_out,
    output logic                      inexact
);

    localparam int PW = 2*MAN_W + 2;

    logic [PW-1:0]    norm;
    logic [MAN_W:0]   kept;
    logic             guard;
    logic             sticky;
    logic             up;
    logic [MAN_W+1:0] sum;

    function automatic logic rne_up(input logic lsb, input logic g, input logic s);
        return g & (s | lsb);
    endfunction

    // Align the leading one to the top bit, round, and renormalise on carry-out
    always_comb begin
        norm    = prod[PW-1] ? prod : (prod << 1);
        kept    = norm[PW-1:MAN_W+1];
        guard   = norm[MAN_W];
        sticky  = |norm[MAN_W-1:0];
        up      = rne_up(kept[0], guard, sticky);
        sum     = {1'b0, kept} + {{(MAN_W+1){1'b0}}, up};
        frac    = sum[MAN_W+1] ? sum[MAN_W:1] : sum[MAN_W-1:0];
        exp_out = exp_in
                + $signed({{(EXP_W+1){1'b0}}, prod[PW-1]})
                + $signed({{(EXP_W+1){1'b0}}, sum[MAN_W+1]});
        inexact = guard | sticky;
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control.
// S1 unpacks/classifies and multiplies significands, S2 normalises and rounds,
// S3 applies special-case priority and registers the packed result and flags.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [EXP_W+MAN_W:0]   i_a,
    input  logic [EXP_W+MAN_W:0]   i_b,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [EXP_W+MAN_W:0]   o_res,
    output logic [3:0]             o_flags
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2*MAN_W + 2;
    localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'(fp_bias(EXP_W));
    localparam logic signed [EXP_W+1:0] EMAX_S = (EXP_W+2)'((1 << EXP_W) - 1);
    localparam logic signed [EXP_W+1:0] ZERO_S = '0;
    localparam logic [W-1:0]            QNAN   = W'(fp_qnan(EXP_W, MAN_W));

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == '0)      return FP_ZERO;   // subnormals flushed to zero
        else if (e == '1) return (f != '0) ? FP_NAN : FP_INF;
        else              return FP_NORM;
    endfunction

    logic en;
    logic vld_p1, vld_p2;

    // S1 combinational results
    fp_class_e               cls_a_s1, cls_b_s1;
    logic                    sign_s1;
    logic signed [EXP_W+1:0] exp_s1;
    logic [PW-1:0]           prod_s1;

    // S1 -> S2 registers
    fp_class_e               cls_a_p1, cls_b_p1;
    logic                    sign_p1;
    logic signed [EXP_W+1:0] exp_p1;
    logic [PW-1:0]           prod_p1;

    // S2 combinational results
    logic [MAN_W-1:0]        frac_s2;
    logic signed [EXP_W+1:0] exp_s2;
    logic                    inexact_s2;

    // S2 -> S3 registers
    fp_class_e               cls_a_p2, cls_b_p2;
    logic                    sign_p2;
    logic signed [EXP_W+1:0] exp_p2;
    logic [MAN_W-1:0]        frac_p2;
    logic                    inexact_p2;

    // S3 combinational results
    logic [W-1:0]            res_s3;
    logic [3:0]              flags_s3;
    logic                    nan_in, inf_in, zero_in;

    assign en      = !o_valid || i_ready;
    assign o_ready = en;

    // S1: unpack, classify, exponent sum and significand product
    always_comb begin
        cls_a_s1 = classify(i_a[W-2:MAN_W], i_a[MAN_W-1:0]);
        cls_b_s1 = classify(i_b[W-2:MAN_W], i_b[MAN_W-1:0]);
        sign_s1  = i_a[W-1] ^ i_b[W-1];
        exp_s1   = $signed({2'b00, i_a[W-2:MAN_W]}) + $signed({2'b00, i_b[W-2:MAN_W]}) - BIAS_S;
        prod_s1  = {{(MAN_W+1){1'b0}}, 1'b1, i_a[MAN_W-1:0]}
                 * {{(MAN_W+1){1'b0}}, 1'b1, i_b[MAN_W-1:0]};
    end

    fp_round_rne #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .prod    (prod_p1),
        .exp_in  (exp_p1),
        .frac    (frac_s2),
        .exp_out (exp_s2),
        .inexact (inexact_s2)
    );

    // S3: special-case priority mux, then pack
    always_comb begin
        res_s3   = '0;
        flags_s3 = '0;
        nan_in   = (cls_a_p2 == FP_NAN)  || (cls_b_p2 == FP_NAN);
        inf_in   = (cls_a_p2 == FP_INF)  || (cls_b_p2 == FP_INF);
        zero_in  = (cls_a_p2 == FP_ZERO) || (cls_b_p2 == FP_ZERO);
        if (nan_in || (inf_in && zero_in)) begin
            res_s3                 = QNAN;
            flags_s3[FLAG_INVALID] = 1'b1;
        end else if (inf_in) begin
            res_s3 = {sign_p2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (zero_in) begin
            res_s3 = {sign_p2, {(W-1){1'b0}}};
        end else if (exp_p2 >= EMAX_S) begin
            res_s3                  = {sign_p2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_s3[FLAG_OVERFLOW] = 1'b1;
            flags_s3[FLAG_INEXACT]  = 1'b1;
        end else if (exp_p2 <= ZERO_S) begin
            res_s3                   = {sign_p2, {(W-1){1'b0}}};
            flags_s3[FLAG_UNDERFLOW] = 1'b1;
            flags_s3[FLAG_INEXACT]   = 1'b1;
        end else begin
            res_s3                 = {sign_p2, exp_p2[EXP_W-1:0], frac_p2};
            flags_s3[FLAG_INEXACT] = inexact_p2;
        end
    end

    // Stage valids advance together whenever the output is free or being taken
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            o_valid <= 1'b0;
        end else if (en) begin
            vld_p1  <= i_valid;
            vld_p2  <= vld_p1;
            o_valid <= vld_p2;
        end
    end

    // Datapath stage registers; contents are qualified by the stage valids
    always_ff @(posedge i_clk) begin
        if (en) begin
            cls_a_p1   <= cls_a_s1;
            cls_b_p1   <= cls_b_s1;
            sign_p1    <= sign_s1;
            exp_p1     <= exp_s1;
            prod_p1    <= prod_s1;
            cls_a_p2   <= cls_a_p1;
            cls_b_p2   <= cls_b_p1;
            sign_p2    <= sign_p1;
            exp_p2     <= exp_s2;
            frac_p2    <= frac_s2;
            inexact_p2 <= inexact_s2;
        end
    end

    // Output registers: load only real results so they stay put across bubbles and stalls
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_res   <= '0;
            o_flags <= '0;
        end else if (en && vld_p2) begin
            o_res   <= res_s3;
            o_flags <= flags_s3;
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for the fp16 configuration of fp_mul_pipe: real-arithmetic reference
// model, scoreboard monitor on the falling edge, directed and streaming stimulus.
module tb_fp_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid, o_ready, o_valid, i_ready;
    logic [15:0] i_a, i_b, o_res;
    logic [3:0]  o_flags;

    int tests = 0;
    int fails = 0;

    logic [19:0] sb[$];
    logic        hold_pending = 1'b0;
    logic [19:0] held;

    fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_res   (o_res),
        .o_flags (o_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: exact product in real arithmetic, then round-to-nearest-even
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, fa, fb, e, ip;
        logic s;
        bit za, zb, ia, ib, na, nb;
        real v, scaled, rem;
        logic [15:0] r;
        logic [3:0] f;
        s  = a[15] ^ b[15];
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        fa = int'(a[9:0]);   fb = int'(b[9:0]);
        za = (ea == 0);  zb = (eb == 0);
        ia = (ea == 31 && fa == 0); ib = (eb == 31 && fb == 0);
        na = (ea == 31 && fa != 0); nb = (eb == 31 && fb != 0);
        r = '0; f = '0;
        if (na || nb || (ia && zb) || (ib && za)) begin
            r = 16'h7E00; f = 4'b1000;
        end else if (ia || ib) begin
            r = {s, 5'h1F, 10'h000};
        end else if (za || zb) begin
            r = {s, 15'h0000};
        end else begin
            v = real'(1024 + fa) * real'(1024 + fb);
            e = ea + eb - 15;
            if (v >= 2097152.0) begin v = v / 2.0; e++; end
            scaled = v / 1024.0;
            ip  = int'($floor(scaled));
            rem = scaled - real'(ip);
            if (rem > 0.5 || (rem == 0.5 && (ip % 2) == 1)) ip++;
            if (ip == 2048) begin ip = 1024; e++; end
            if (e >= 31) begin
                r = {s, 5'h1F, 10'h000}; f = 4'b0101;
            end else if (e <= 0) begin
                r = {s, 15'h0000}; f = 4'b0011;
            end else begin
                r = {s, 5'(e), 10'(ip - 1024)}; f = {3'b000, rem != 0.0};
            end
        end
        return {r, f};
    endfunction

    // Monitor: record accepted operands, check every delivered result and every stall
    always @(negedge clk) begin
        logic [19:0] exp_v;
        if (!rst_n) begin
            hold_pending <= 1'b0;
        end else begin
            if (hold_pending) begin
                chk("hold_valid", 32'(o_valid), 32'd1);
                chk("hold_data", 32'({o_res, o_flags}), 32'(held));
            end
            if (o_valid && !i_ready) begin
                chk("stall_o_ready", 32'(o_ready), 32'd0);
                hold_pending <= 1'b1;
                held         <= {o_res, o_flags};
            end else begin
                hold_pending <= 1'b0;
            end
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'({o_res, o_flags}), 32'hFFFF_FFFF);
                end else begin
                    exp_v = sb.pop_front();
                    chk("sb_res", 32'(o_res), 32'(exp_v[19:4]));
                    chk("sb_flags", 32'(o_flags), 32'(exp_v[3:0]));
                end
            end
            if (i_valid && o_ready) sb.push_back(model(i_a, i_b));
        end
    end

    // Present one operand pair and hold it until the block takes it
    task automatic send(input logic [15:0] a, input logic [15:0] b);
        logic acc;
        int   guard;
        i_a = a; i_b = b; i_valid = 1'b1;
        guard = 0;
        do begin
            @(negedge clk); acc = o_ready;
            @(posedge clk); #1;
            guard++;
        end while (!acc && guard < 200);
        if (!acc) chk("send_timeout", 32'(guard), 32'd0);
    endtask

    // Single transaction with literal expectation and latency measurement
    task automatic single(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input logic [3:0] ef);
        int lat;
        i_ready = 1'b1;
        send(a, b);
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        chk({name, "_lat"}, 32'(lat), 32'd3);
        chk({name, "_res"}, 32'(o_res), 32'(er));
        chk({name, "_flags"}, 32'(o_flags), 32'(ef));
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    logic [15:0] va[8] = '{16'h3C00, 16'h3E00, 16'h3C01, 16'h7BFF, 16'h0400, 16'h7C00, 16'hFC00, 16'h8000};
    logic [15:0] vb[8] = '{16'h4000, 16'h3E00, 16'h3E00, 16'h7BFF, 16'h0400, 16'h0000, 16'h4000, 16'h3C00};
    logic [15:0] vr[8] = '{16'h4000, 16'h4080, 16'h3E02, 16'h7C00, 16'h0000, 16'h7E00, 16'hFC00, 16'h8000};
    logic [3:0]  vf[8] = '{4'b0000, 4'b0000, 4'b0001, 4'b0101, 4'b0011, 4'b1000, 4'b0000, 4'b0000};

    initial begin
        bit drv_done;
        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_a = '0; i_b = '0;
        #12;
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_res", 32'(o_res), 32'd0);
        chk("rst_o_flags", 32'(o_flags), 32'd0);
        chk("rst_o_ready", 32'(o_ready), 32'd1);
        @(posedge clk); #1; rst_n = 1'b1;

        // Pin the reference model itself against hand-computed results
        for (int i = 0; i < 8; i++) begin
            logic [19:0] m;
            m = model(va[i], vb[i]);
            chk($sformatf("model_%0d", i), 32'(m), 32'({vr[i], vf[i]}));
        end

        // Directed single operations
        for (int i = 0; i < 8; i++) single($sformatf("dir_%0d", i), va[i], vb[i], vr[i], vf[i]);
        drain("dir_drain");

        // Back-to-back stream with a three-cycle sink stall in the middle
        fork
            begin
                for (int i = 0; i < 8; i++) send(va[i], vb[i]);
                i_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 i_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 i_ready = 1'b1;
            end
        join
        drain("stream_drain");

        // Random sink back-pressure against the scoreboard
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if (i % 3 == 0) send(va[i % 8], vb[(i / 8) % 8]);
                    else            send(16'($urandom), 16'($urandom));
                end
                i_valid = 1'b0;
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk); #1 i_ready = 1'($urandom_range(0, 1));
                end
                i_ready = 1'b1;
            end
        join
        drain("random_drain");

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) send(va[i], vb[i]);
        i_valid = 1'b0;
        chk("inflight_o_valid", 32'(o_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_o_valid", 32'(o_valid), 32'd0);
        chk("midrst_o_res", 32'(o_res), 32'd0);
        chk("midrst_o_flags", 32'(o_flags), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("postrst_no_stale", 32'(o_valid), 32'd0);
        end
        @(posedge clk); #1;
        single("postrst_op", 16'h3C00, 16'h4000, 16'h4000, 4'b0000);
        drain("final_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
